// File: rtl/aes_key_schedule.sv
// AES key expansion for 128/192/256-bit keys: one 32-bit word per cycle,
// delivered as 128-bit round keys over a valid/ready handshake.
module aes_key_schedule #(
  parameter bit KEY192_EN = 1'b1,
  parameter bit KEY256_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         err,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         rk_last
);

  typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = '0;
    t = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, t, v;
    x2  = gmul(x, x);
    x3  = gmul(x2, x);
    x12 = gmul(x3, x3);
    x12 = gmul(x12, x12);
    t   = gmul(x12, x3);
    for (int n = 0; n < 4; n++) t = gmul(t, t);
    t   = gmul(t, x12);
    v   = gmul(t, x2);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  state_t           state_q;
  logic [7:0][31:0] win_q;
  logic [3:0][31:0] buf_q;
  logic [5:0]       i_q;
  logic [2:0]       k_q;
  logic [7:0]       rcon_q;
  logic [1:0]       len_q;
  logic             pend_q;
  logic [3:0]       rnd_q;
  logic             err_q, rk_valid_q, rk_last_q;
  logic [127:0]     rk_data_q;
  logic [3:0]       rk_idx_q;

  logic [3:0]       nk, nr, nk_in;
  logic [2:0]       nk_m1;
  logic             legal, accept, past_key, last_word;
  logic             out_free, load_out, produce, xfer;
  logic [31:0]      prev, oldest, sub_in, sub_out, word_d;
  logic [7:0][31:0] kw, key_win;

  always_comb begin
    case (len_q)
      2'd1:    begin nk = 4'd6; nr = 4'd12; end
      2'd2:    begin nk = 4'd8; nr = 4'd14; end
      default: begin nk = 4'd4; nr = 4'd10; end
    endcase
    case (key_len)
      2'd0:    begin legal = 1'b1;      nk_in = 4'd4; end
      2'd1:    begin legal = KEY192_EN; nk_in = 4'd6; end
      2'd2:    begin legal = KEY256_EN; nk_in = 4'd8; end
      default: begin legal = 1'b0;      nk_in = 4'd4; end
    endcase
  end

  // Key is preloaded oldest-first so the first Nk words just rotate out of the window.
  assign kw = key_in;
  always_comb begin
    logic [2:0] src;
    key_win = '0;
    for (int j = 0; j < 8; j++) begin
      src = 3'(nk_in - 4'd1 - 4'(j));
      if (4'(j) < nk_in) key_win[j] = kw[src];
    end
  end

  assign nk_m1     = 3'(nk - 4'd1);
  assign prev      = win_q[0];
  assign oldest    = win_q[nk_m1];
  assign past_key  = {2'b00, nk} <= i_q;
  assign last_word = i_q == {nr, 2'b11};
  assign sub_in    = (k_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
  assign sub_out   = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};

  always_comb begin
    word_d = oldest ^ prev;
    if (!past_key)                       word_d = oldest;
    else if (k_q == 3'd0)                word_d = oldest ^ sub_out ^ {rcon_q, 24'h0};
    else if (nk == 4'd8 && k_q == 3'd4)  word_d = oldest ^ sub_out;
  end

  assign accept   = (state_q == IDLE) && start;
  assign out_free = !rk_valid_q || rk_ready;
  assign load_out = pend_q && out_free;
  assign produce  = (state_q == GEN) && (!pend_q || out_free);
  assign xfer     = rk_valid_q && rk_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      win_q      <= '0;
      buf_q      <= '0;
      i_q        <= '0;
      k_q        <= '0;
      rcon_q     <= 8'h01;
      len_q      <= '0;
      pend_q     <= 1'b0;
      rnd_q      <= '0;
      err_q      <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_data_q  <= '0;
      rk_idx_q   <= '0;
      rk_last_q  <= 1'b0;
    end else begin
      err_q <= accept && !legal;
      if (accept && legal) begin
        state_q <= GEN;
        len_q   <= key_len;
        win_q   <= key_win;
        i_q     <= '0;
        k_q     <= '0;
        rcon_q  <= 8'h01;
        rnd_q   <= '0;
        pend_q  <= 1'b0;
      end
      if (produce) begin
        win_q            <= {win_q[6:0], word_d};
        buf_q[i_q[1:0]]  <= word_d;
        i_q              <= i_q + 6'd1;
        k_q              <= (k_q == nk_m1) ? 3'd0 : k_q + 3'd1;
        pend_q           <= i_q[1:0] == 2'd3;
        if (past_key && k_q == 3'd0) rcon_q <= xtime(rcon_q);
        if (last_word) state_q <= DRAIN;
      end else if (load_out) begin
        pend_q <= 1'b0;
      end
      if (load_out) begin
        rk_valid_q <= 1'b1;
        rk_data_q  <= buf_q;
        rk_idx_q   <= rnd_q;
        rk_last_q  <= rnd_q == nr;
        rnd_q      <= rnd_q + 4'd1;
      end else if (xfer) begin
        rk_valid_q <= 1'b0;
        rk_last_q  <= 1'b0;
      end
      if (state_q == DRAIN && xfer && rk_last_q) state_q <= IDLE;
    end
  end

  assign busy     = state_q != IDLE;
  assign err      = err_q;
  assign rk_valid = rk_valid_q;
  assign rk_data  = rk_data_q;
  assign rk_idx   = rk_idx_q;
  assign rk_last  = rk_last_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule using FIPS-197 expansion vectors.
module tb_aes_key_schedule;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'd0;
  logic [255:0] key_in = '0;
  logic         rk_ready = 1'b0;
  logic         busy, err, rk_valid, rk_last;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;

  int passed = 0;
  int total  = 0;

  localparam logic [255:0] K128 = {128'h0, 32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
  localparam logic [255:0] K192 = {64'h0, 32'h522c6b7b, 32'h62f8ead2, 32'h809079e5,
                                   32'hc810f32b, 32'hda0e6452, 32'h8e73b0f7};
  localparam logic [255:0] K256 = {32'h1c1d1e1f, 32'h18191a1b, 32'h14151617, 32'h10111213,
                                   32'h0c0d0e0f, 32'h08090a0b, 32'h04050607, 32'h00010203};
  localparam logic [127:0] R128_0  = {32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
  localparam logic [127:0] R128_1  = {32'h2a6c7605, 32'h23a33939, 32'h88542cb1, 32'ha0fafe17};
  localparam logic [127:0] R128_2  = {32'h7359f67f, 32'h5935807a, 32'h7a96b943, 32'hf2c295f2};
  localparam logic [127:0] R128_10 = {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8};
  localparam logic [127:0] R192_0  = {32'h809079e5, 32'hc810f32b, 32'hda0e6452, 32'h8e73b0f7};
  localparam logic [127:0] R192_1  = {32'h2402f5a5, 32'hfe0c91f7, 32'h522c6b7b, 32'h62f8ead2};
  localparam logic [127:0] R256_1  = {32'h1c1d1e1f, 32'h18191a1b, 32'h14151617, 32'h10111213};
  localparam logic [127:0] R256_14 = {32'h6d68de36, 32'h371ac23c, 32'hbf0979e9, 32'h24fc79cc};

  always #5 clk = ~clk;

  aes_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key_in(key_in),
    .busy(busy), .err(err), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_data(rk_data), .rk_idx(rk_idx), .rk_last(rk_last)
  );

  logic [127:0] cap_data [16];
  logic [3:0]   cap_idx  [16];
  logic         cap_last [16];
  int           cap_cyc  [16];
  int           cap_n, cap_lat, cap_unstable, cap_err_seen;
  bit           cap_to, cap_busy_end;

  // Drives one schedule and records every transferred round key.
  task automatic run_sched(input logic [1:0] len, input logic [255:0] key,
                           input bit rnd_rdy, input bit spam);
    int cyc;
    bit done, stall;
    logic [127:0] hd;
    logic [3:0]   hi;
    logic         hl;
    cap_n = 0; cap_lat = -1; cap_unstable = 0; cap_err_seen = 0;
    done = 0; stall = 0; hd = '0; hi = '0; hl = 1'b0;
    start = 1'b1; key_len = len; key_in = key; rk_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 400) begin
      if (err) cap_err_seen++;
      if (stall && (!rk_valid || rk_data !== hd || rk_idx !== hi || rk_last !== hl)) cap_unstable++;
      if (rk_valid && cap_lat < 0) cap_lat = cyc;
      if (spam) begin
        start   = (cyc == 10);
        key_len = (cyc == 10) ? 2'd3 : len;
        key_in  = (cyc == 10) ? ~key : key;
      end
      rk_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      stall = rk_valid && !rk_ready;
      hd = rk_data; hi = rk_idx; hl = rk_last;
      if (rk_valid && rk_ready) begin
        cap_data[cap_n] = rk_data;
        cap_idx[cap_n]  = rk_idx;
        cap_last[cap_n] = rk_last;
        cap_cyc[cap_n]  = cyc;
        cap_n++;
        if (rk_last || cap_n == 16) done = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    key_len = len;
    cap_to = !done;
    cap_busy_end = busy;
  endtask

  task automatic test_reset();
    #3;
    total++; if ({busy, err, rk_valid, rk_last} !== 4'b0) $display("FAIL reset_flags: got %b expected 0000", {busy, err, rk_valid, rk_last}); else passed++;
    total++; if (rk_data !== 128'h0 || rk_idx !== 4'h0) $display("FAIL reset_data: got %h/%h expected 0/0", rk_data, rk_idx); else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || rk_valid !== 1'b0) $display("FAIL reset_release: got busy=%b valid=%b expected 0 0", busy, rk_valid); else passed++;
  endtask

  task automatic test_aes128();
    run_sched(2'd0, K128, 1'b0, 1'b0);
    total++; if (cap_to !== 1'b0) $display("FAIL a128_timeout: got %0d expected 0", cap_to); else passed++;
    total++; if (cap_n !== 11) $display("FAIL a128_count: got %0d expected 11", cap_n); else passed++;
    total++; if (cap_lat !== 5) $display("FAIL a128_latency: got %0d expected 5", cap_lat); else passed++;
    total++; if (cap_cyc[10] !== 45) $display("FAIL a128_rate: got %0d expected 45", cap_cyc[10]); else passed++;
    total++; if (cap_data[0] !== R128_0) $display("FAIL a128_rk0: got %h expected %h", cap_data[0], R128_0); else passed++;
    total++; if (cap_data[1] !== R128_1) $display("FAIL a128_rk1: got %h expected %h", cap_data[1], R128_1); else passed++;
    total++; if (cap_data[2] !== R128_2) $display("FAIL a128_rk2: got %h expected %h", cap_data[2], R128_2); else passed++;
    total++; if (cap_data[10] !== R128_10) $display("FAIL a128_rk10: got %h expected %h", cap_data[10], R128_10); else passed++;
    total++; if (cap_last[10] !== 1'b1 || cap_last[9] !== 1'b0) $display("FAIL a128_last: got %b%b expected 01", cap_last[9], cap_last[10]); else passed++;
    for (int k = 0; k < 11; k++) begin
      total++; if (cap_idx[k] !== 4'(k)) $display("FAIL a128_idx: got %0d expected %0d", cap_idx[k], k); else passed++;
    end
    total++; if (cap_busy_end !== 1'b0) $display("FAIL a128_busy_end: got %b expected 0", cap_busy_end); else passed++;
  endtask

  task automatic test_aes192();
    run_sched(2'd1, K192, 1'b0, 1'b0);
    total++; if (cap_n !== 13) $display("FAIL a192_count: got %0d expected 13", cap_n); else passed++;
    total++; if (cap_data[0] !== R192_0) $display("FAIL a192_rk0: got %h expected %h", cap_data[0], R192_0); else passed++;
    total++; if (cap_data[1] !== R192_1) $display("FAIL a192_rk1: got %h expected %h", cap_data[1], R192_1); else passed++;
    total++; if (cap_idx[12] !== 4'd12 || cap_last[12] !== 1'b1) $display("FAIL a192_last: got %0d/%b expected 12/1", cap_idx[12], cap_last[12]); else passed++;
  endtask

  task automatic test_aes256();
    run_sched(2'd2, K256, 1'b0, 1'b0);
    total++; if (cap_n !== 15) $display("FAIL a256_count: got %0d expected 15", cap_n); else passed++;
    total++; if (cap_data[1] !== R256_1) $display("FAIL a256_rk1: got %h expected %h", cap_data[1], R256_1); else passed++;
    total++; if (cap_data[14] !== R256_14) $display("FAIL a256_rk14: got %h expected %h", cap_data[14], R256_14); else passed++;
    total++; if (cap_idx[14] !== 4'd14 || cap_last[14] !== 1'b1) $display("FAIL a256_last: got %0d/%b expected 14/1", cap_idx[14], cap_last[14]); else passed++;
  endtask

  task automatic test_back_to_back();
    run_sched(2'd0, K128, 1'b0, 1'b0);
    total++; if (cap_n !== 11) $display("FAIL b2b_count: got %0d expected 11", cap_n); else passed++;
    total++; if (cap_lat !== 5) $display("FAIL b2b_latency: got %0d expected 5", cap_lat); else passed++;
    total++; if (cap_data[1] !== R128_1) $display("FAIL b2b_rk1: got %h expected %h", cap_data[1], R128_1); else passed++;
    total++; if (cap_data[10] !== R128_10) $display("FAIL b2b_rk10: got %h expected %h", cap_data[10], R128_10); else passed++;
  endtask

  task automatic test_backpressure();
    run_sched(2'd0, K128, 1'b1, 1'b0);
    total++; if (cap_to !== 1'b0 || cap_n !== 11) $display("FAIL bp_count: got %0d (timeout %0d) expected 11", cap_n, cap_to); else passed++;
    total++; if (cap_unstable !== 0) $display("FAIL bp_stable: got %0d changes expected 0", cap_unstable); else passed++;
    total++; if (cap_data[0] !== R128_0) $display("FAIL bp_rk0: got %h expected %h", cap_data[0], R128_0); else passed++;
    total++; if (cap_data[1] !== R128_1) $display("FAIL bp_rk1: got %h expected %h", cap_data[1], R128_1); else passed++;
    total++; if (cap_data[2] !== R128_2) $display("FAIL bp_rk2: got %h expected %h", cap_data[2], R128_2); else passed++;
    total++; if (cap_data[10] !== R128_10) $display("FAIL bp_rk10: got %h expected %h", cap_data[10], R128_10); else passed++;
    for (int k = 0; k < 11; k++) begin
      total++; if (cap_idx[k] !== 4'(k)) $display("FAIL bp_idx: got %0d expected %0d", cap_idx[k], k); else passed++;
    end
    total++; if (cap_busy_end !== 1'b0) $display("FAIL bp_busy_end: got %b expected 0", cap_busy_end); else passed++;
    rk_ready = 1'b1;
  endtask

  task automatic test_err();
    start = 1'b1; key_len = 2'd3; key_in = K128;
    @(posedge clk); #1;
    start = 1'b0; key_len = 2'd0;
    total++; if (err !== 1'b1 || busy !== 1'b0) $display("FAIL err_pulse: got err=%b busy=%b expected 1 0", err, busy); else passed++;
    @(posedge clk); #1;
    total++; if (err !== 1'b0 || busy !== 1'b0 || rk_valid !== 1'b0) $display("FAIL err_clear: got err=%b busy=%b valid=%b expected 0 0 0", err, busy, rk_valid); else passed++;
  endtask

  task automatic test_busy_start();
    run_sched(2'd0, K128, 1'b0, 1'b1);
    total++; if (cap_err_seen !== 0) $display("FAIL busy_start_err: got %0d expected 0", cap_err_seen); else passed++;
    total++; if (cap_n !== 11) $display("FAIL busy_start_count: got %0d expected 11", cap_n); else passed++;
    total++; if (cap_data[1] !== R128_1) $display("FAIL busy_start_rk1: got %h expected %h", cap_data[1], R128_1); else passed++;
    total++; if (cap_data[10] !== R128_10) $display("FAIL busy_start_rk10: got %h expected %h", cap_data[10], R128_10); else passed++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    int seen;
    bit found;
    start = 1'b1; key_len = 2'd0; key_in = K128; rk_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    cyc = 0;
    while (!found && cyc < 100) begin
      if (rk_valid && rk_idx == 4'd5) found = 1;
      else begin @(posedge clk); #1; cyc++; end
    end
    total++; if (found !== 1'b1) $display("FAIL mid_reach_round5: got %b expected 1", found); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if ({busy, err, rk_valid, rk_last} !== 4'b0) $display("FAIL mid_reset_flags: got %b expected 0000", {busy, err, rk_valid, rk_last}); else passed++;
    total++; if (rk_data !== 128'h0 || rk_idx !== 4'h0) $display("FAIL mid_reset_data: got %h/%h expected 0/0", rk_data, rk_idx); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (rk_valid || busy) seen++;
    end
    total++; if (seen !== 0) $display("FAIL mid_no_output: got %0d active cycles expected 0", seen); else passed++;
    run_sched(2'd0, K128, 1'b0, 1'b0);
    total++; if (cap_lat !== 5) $display("FAIL mid_restart_latency: got %0d expected 5", cap_lat); else passed++;
    total++; if (cap_data[0] !== R128_0) $display("FAIL mid_restart_rk0: got %h expected %h", cap_data[0], R128_0); else passed++;
    total++; if (cap_data[1] !== R128_1) $display("FAIL mid_restart_rk1: got %h expected %h", cap_data[1], R128_1); else passed++;
  endtask

  initial begin
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_back_to_back();
    test_backpressure();
    test_err();
    test_busy_start();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

Interface
REQ-001 The parameter KEY192_EN SHALL default to 1 and, when 1, enable AES-192 support.
REQ-002 The parameter KEY256_EN SHALL default to 1 and, when 1, enable AES-256 support.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset; asynchronous, active-low.
REQ-005 start  input  1  SHALL be the key-load request, accepted only while busy=0.
REQ-006 key_len  input  2  SHALL select key size: 00=128, 01=192, 10=256, 11=reserved; sampled with start.
REQ-007 key_in  input  256  SHALL carry the cipher key; word j = key_in[32j+31:32j]; only words 0..Nk-1 are used; sampled with start.
REQ-008 busy  output  1  SHALL be high from the cycle after an accepted start until the last round key handshake completes.
REQ-009 err  output  1  SHALL pulse high for one cycle when start arrives with reserved or disabled key_len.
REQ-010 rk_valid  output  1  SHALL mark rk_data valid.
REQ-011 rk_ready  input  1  SHALL be the consumer acceptance; a transfer occurs when rk_valid and rk_ready are both high.
REQ-012 rk_data  output  128  SHALL be round key r = {w[4r+3], w[4r+2], w[4r+1], w[4r]}.
REQ-013 rk_idx  output  4  SHALL give round index r of rk_data.
REQ-014 rk_last  output  1  SHALL be high with rk_valid on round key Nr.

Function
REQ-015 Byte 0 of every word SHALL occupy bits [31:24]; RotWord moves bits [23:0] to [31:8] and [31:24] to [7:0]; Rcon is XORed into bits [31:24].
REQ-016 Nk/Nr SHALL be 4/10, 6/12, 8/14; total words 4*(Nr+1) = 44, 52, 60.
REQ-017 States SHALL be IDLE, GEN, DRAIN; IDLE->GEN on accepted legal start; GEN->DRAIN after last word produced; DRAIN->IDLE on last round key transfer.
REQ-018 GEN SHALL produce one word w[i] per unstalled cycle, i from 0: i<Nk -> key word i; otherwise w[i-Nk] XOR temp.
REQ-019 temp SHALL be SubWord(RotWord(w[i-1])) XOR Rcon when i mod Nk = 0; SubWord(w[i-1]) when Nk=8 and i mod Nk = 4; otherwise w[i-1].
REQ-020 Rcon SHALL start at 0x01 and advance by GF(2^8) doubling (poly 0x11B) after each use: 01,02,04,...,80,1B,36.
REQ-021 A sliding window of the last Nk (max 8) words and a 4-word assembly buffer SHALL hold state; the four S-box lookups are combinational within the module.
REQ-022 When the 4th word of a round key is produced, it SHALL load rk_data/rk_idx/rk_last in the next cycle if the output register is empty or transferring that cycle; otherwise GEN stalls, with window, index and Rcon held.
REQ-023 With rk_ready constantly high, round key 0 SHALL be valid 5 cycles after start acceptance, then one round key every 4 cycles, with no stall.
REQ-024 rk_data, rk_idx and rk_last SHALL be stable while rk_valid=1 and rk_ready=0.
REQ-025 start while busy=1 SHALL be ignored without err; err and start in the same cycle SHALL leave state IDLE.
REQ-026 With KEY192_EN=0 or KEY256_EN=0, the corresponding key_len SHALL be treated as reserved; the associated window width need not be synthesised.
REQ-027 A new start accepted in the cycle after DRAIN->IDLE SHALL be processed normally, using a fresh Rcon and index.

Reset
REQ-028 On rst_n low, asynchronously: state=IDLE, busy=0, err=0, rk_valid=0, rk_data=0, rk_idx=0, rk_last=0, window and buffer=0, Rcon=0x01.
REQ-029 Reset asserted mid-GEN or mid-DRAIN SHALL abort the schedule; no round key is emitted after release until a new start.

Verification
REQ-030 AES-128 key 2b7e1516 28aed2a6 abf71588 09cf4f3c (word0..3), rk_ready=1 -> rk_idx=1 rk_data words 0..3 = a0fafe17 88542cb1 23a33939 2a6c7605; rk_idx=10 words = d014f9a8 c9ee2589 e13f0cc8 b6630ca6 with rk_last=1.
REQ-031 AES-192 key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> rk_idx=1 words = 62f8ead2 522c6b7b fe0c91f7 2402f5a5; 13 round keys total.
REQ-032 AES-256 key bytes 00..1f -> rk_idx=14 rk_data words = 24fc79cc bf0979e9 371ac23c 6d68de36, rk_last=1; 15 round keys total.
REQ-033 Random rk_ready backpressure on AES-128 -> identical round-key sequence to REQ-030, rk_data stable while stalled, busy falls after idx 10 transfer.
REQ-034 key_len=11 with start -> err pulses one cycle, busy stays 0; start while busy -> ignored, sequence unchanged.
REQ-035 rst_n low during GEN at round 5 -> all outputs 0 immediately; after release and new start, round 0 appears 5 cycles after acceptance.
